// File: rtl/detector_emulator.sv
// detector_emulator: replays one Avalon-ST video frame per trigger edge onto a
// detector-style parallel bus (vsync envelope, hsync per line, 14-bit video).
// The frame is aligned on start-of-packet. Missing beats, misplaced packet
// markers and triggers that arrive mid-frame are reported through sticky
// status bits.
module detector_emulator #(
    parameter int ACTIVE_WIDTH = 640,
    parameter int ACTIVE_LINES = 512,
    parameter int HBLANK       = 16,
    parameter int VSYNC_LEAD   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        din_startofpacket,
    input  logic        din_endofpacket,
    input  logic        din_valid,
    input  logic [13:0] din_data,
    output logic        din_ready,
    input  logic        dd_seq_trigger,
    output logic        dd_vsync,
    output logic        dd_hsync,
    output logic [13:0] dd_video,
    input  logic        sts_clear,
    output logic        sts_underflow,
    output logic        sts_frame_error,
    output logic        sts_trigger_overrun
);

    localparam int PIX_W  = $clog2(ACTIVE_WIDTH + HBLANK);
    localparam int LINE_W = (ACTIVE_LINES > 1) ? $clog2(ACTIVE_LINES) : 1;
    localparam int LEAD_W = (VSYNC_LEAD > 1) ? $clog2(VSYNC_LEAD) : 1;

    localparam logic [PIX_W-1:0]  PIX_LAST_ACT = PIX_W'(ACTIVE_WIDTH - 1);
    localparam logic [PIX_W-1:0]  PIX_LAST     = PIX_W'(ACTIVE_WIDTH + HBLANK - 1);
    localparam logic [LINE_W-1:0] LINE_LAST    = LINE_W'(ACTIVE_LINES - 1);
    localparam logic [LEAD_W-1:0] LEAD_LAST    = LEAD_W'(VSYNC_LEAD - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ALIGN,
        S_LEAD,
        S_ACTIVE,
        S_BLANK
    } state_t;

    state_t              state_reg, state_next;
    logic [PIX_W-1:0]    pix_cnt_reg, pix_cnt_next;
    logic [LINE_W-1:0]   line_cnt_reg, line_cnt_next;
    logic [LEAD_W-1:0]   lead_cnt_reg, lead_cnt_next;
    logic                trigger_q_reg;
    logic                eop_seen_reg, eop_seen_next;
    logic [13:0]         video_next;
    logic                underflow_set, frame_error_set, overrun_set;
    logic                trig_edge, first_pix, last_pix, accept;

    logic                vsync_reg, hsync_reg;
    logic [13:0]         video_reg;
    logic                underflow_reg, frame_error_reg, overrun_reg;

    assign trig_edge = dd_seq_trigger & ~trigger_q_reg;
    assign first_pix = (pix_cnt_reg == '0) && (line_cnt_reg == '0);
    assign last_pix  = (pix_cnt_reg == PIX_LAST_ACT) && (line_cnt_reg == LINE_LAST);

    // Frame sequencer: next state, counters, sink ready, pixel and status events.
    always_comb begin
        state_next      = state_reg;
        pix_cnt_next    = pix_cnt_reg;
        line_cnt_next   = line_cnt_reg;
        lead_cnt_next   = lead_cnt_reg;
        eop_seen_next   = eop_seen_reg;
        din_ready       = 1'b0;
        accept          = 1'b0;
        video_next      = '0;
        underflow_set   = 1'b0;
        frame_error_set = 1'b0;
        overrun_set     = trig_edge && (state_reg != S_IDLE);

        case (state_reg)
            S_IDLE: begin
                if (trig_edge) begin
                    state_next    = S_ALIGN;
                    pix_cnt_next  = '0;
                    line_cnt_next = '0;
                    lead_cnt_next = '0;
                end
            end
            S_ALIGN: begin
                // Junk ahead of the sop is drained; the sop itself stays on
                // the bus so it becomes the first pixel of the frame.
                din_ready = ~(din_valid & din_startofpacket);
                if (din_valid && din_startofpacket) begin
                    state_next    = S_LEAD;
                    eop_seen_next = 1'b0;
                    lead_cnt_next = '0;
                end
            end
            S_LEAD: begin
                if (lead_cnt_reg == LEAD_LAST) begin
                    state_next    = S_ACTIVE;
                    pix_cnt_next  = '0;
                    line_cnt_next = '0;
                end else begin
                    lead_cnt_next = lead_cnt_reg + 1'b1;
                end
            end
            S_ACTIVE: begin
                // Pixel slots advance every cycle; the stream must keep up.
                din_ready     = ~eop_seen_reg;
                accept        = din_valid & ~eop_seen_reg;
                underflow_set = ~din_valid & ~eop_seen_reg;
                if (accept) begin
                    video_next = din_data;
                    if (din_endofpacket) begin
                        eop_seen_next = 1'b1;
                        if (!last_pix) frame_error_set = 1'b1;
                    end else if (last_pix) begin
                        frame_error_set = 1'b1;
                    end
                    if (din_startofpacket && !first_pix) frame_error_set = 1'b1;
                end
                pix_cnt_next = pix_cnt_reg + 1'b1;
                if (pix_cnt_reg == PIX_LAST_ACT) state_next = S_BLANK;
            end
            S_BLANK: begin
                if (pix_cnt_reg == PIX_LAST) begin
                    pix_cnt_next = '0;
                    if (line_cnt_reg == LINE_LAST) begin
                        state_next = S_IDLE;
                    end else begin
                        line_cnt_next = line_cnt_reg + 1'b1;
                        state_next    = S_ACTIVE;
                    end
                end else begin
                    pix_cnt_next = pix_cnt_reg + 1'b1;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // State, counters, output register and sticky status (set beats clear).
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= S_IDLE;
            pix_cnt_reg     <= '0;
            line_cnt_reg    <= '0;
            lead_cnt_reg    <= '0;
            trigger_q_reg   <= 1'b0;
            eop_seen_reg    <= 1'b0;
            vsync_reg       <= 1'b0;
            hsync_reg       <= 1'b0;
            video_reg       <= '0;
            underflow_reg   <= 1'b0;
            frame_error_reg <= 1'b0;
            overrun_reg     <= 1'b0;
        end else begin
            state_reg       <= state_next;
            pix_cnt_reg     <= pix_cnt_next;
            line_cnt_reg    <= line_cnt_next;
            lead_cnt_reg    <= lead_cnt_next;
            trigger_q_reg   <= dd_seq_trigger;
            eop_seen_reg    <= eop_seen_next;
            vsync_reg       <= (state_reg == S_LEAD) || (state_reg == S_ACTIVE) ||
                               (state_reg == S_BLANK);
            hsync_reg       <= (state_reg == S_ACTIVE);
            video_reg       <= video_next;
            underflow_reg   <= underflow_set   | (underflow_reg   & ~sts_clear);
            frame_error_reg <= frame_error_set | (frame_error_reg & ~sts_clear);
            overrun_reg     <= overrun_set     | (overrun_reg     & ~sts_clear);
        end
    end

    assign dd_vsync            = vsync_reg;
    assign dd_hsync            = hsync_reg;
    assign dd_video            = video_reg;
    assign sts_underflow       = underflow_reg;
    assign sts_frame_error     = frame_error_reg;
    assign sts_trigger_overrun = overrun_reg;

endmodule
